// File: rtl/canon_pkg.sv
// Shared types, mode encodings and width helpers for the canonical-form term sweeper.
package canon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_POS = 1'b0;
  localparam logic MODE_SOP = 1'b1;

  function automatic int unsigned terms_of(input int unsigned n_vars);
    return 32'd1 << n_vars;
  endfunction

  // Count reaches TERMS itself when every index is true, hence one extra bit.
  function automatic int unsigned cnt_width(input int unsigned n_vars);
    return n_vars + 32'd1;
  endfunction

endpackage

// File: rtl/canon_term_sweeper_if.sv
// Valid/ready stream carrying (index, value) pairs out of the term sweeper.
interface canon_term_sweeper_if #(
  parameter int unsigned N_VARS = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [N_VARS-1:0] out_idx;
  logic              out_s;

  modport master (
    output out_valid,
    output out_idx,
    output out_s,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_s,
    output out_ready
  );
endinterface

// File: rtl/canon_lut.sv
// Combinational truth-table lookup: term-mask bit at idx, XNOR'ed with the SoP/PoS mode.
module canon_lut
  import canon_pkg::*;
#(
  parameter int unsigned N_VARS = 3,
  localparam int unsigned TERMS = terms_of(N_VARS)
) (
  input  logic [TERMS-1:0]  mask,
  input  logic              mode,
  input  logic [N_VARS-1:0] idx,
  output logic              s
);

  assign s = ~(mask[idx] ^ mode);

endmodule

// File: rtl/canon_term_sweeper.sv
// Sequential SoP/PoS evaluator sweeping all input combinations over a valid/ready stream.
// Optional registered lookup port enabled by defining CANON_EVAL_PORT_EN.
module canon_term_sweeper
  import canon_pkg::*;
#(
  parameter int unsigned N_VARS = 3,
  localparam int unsigned TERMS = terms_of(N_VARS),
  localparam int unsigned CW    = cnt_width(N_VARS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [TERMS-1:0]     term_mask,
  input  logic                 mode,
  input  logic                 start,
  canon_term_sweeper_if.master stream,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        ones_cnt
`ifdef CANON_EVAL_PORT_EN
  ,
  input  logic [N_VARS-1:0]    eval_in,
  output logic                 eval_s
`endif
);

  state_e            state;
  logic [TERMS-1:0]  mask_q;
  logic              mode_q;
  logic              out_valid;
  logic [N_VARS-1:0] out_idx;
  logic              out_s;

  logic [TERMS-1:0]  lut_mask;
  logic              lut_mode;
  logic [N_VARS-1:0] lut_idx;
  logic              lut_s;

  assign stream.out_valid = out_valid;
  assign stream.out_idx   = out_idx;
  assign stream.out_s     = out_s;

  // The lookup always targets the index about to be registered, so out_s and
  // out_idx update together; a load coincident with start feeds the new mask in.
  always_comb begin
    lut_mask = mask_q;
    lut_mode = mode_q;
    lut_idx  = out_idx + 1'b1;
    if (state == IDLE) begin
      lut_idx = '0;
      if (load) begin
        lut_mask = term_mask;
        lut_mode = mode;
      end
    end
  end

  canon_lut #(.N_VARS(N_VARS)) u_sweep_lut (
    .mask (lut_mask),
    .mode (lut_mode),
    .idx  (lut_idx),
    .s    (lut_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '0;
      mode_q    <= MODE_POS;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_s     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ones_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            mask_q <= term_mask;
            mode_q <= mode;
          end
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_s     <= lut_s;
            ones_cnt  <= '0;
          end
        end
        SWEEP: begin
          if (out_valid && stream.out_ready) begin
            ones_cnt <= ones_cnt + CW'(out_s);
            if (out_idx == '1) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx <= lut_idx;
              out_s   <= lut_s;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (load) begin
            mask_q <= term_mask;
            mode_q <= mode;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CANON_EVAL_PORT_EN
  logic eval_lut_s;

  canon_lut #(.N_VARS(N_VARS)) u_eval_lut (
    .mask (mask_q),
    .mode (mode_q),
    .idx  (eval_in),
    .s    (eval_lut_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_s <= 1'b0;
    end else begin
      eval_s <= eval_lut_s;
    end
  end
`endif

endmodule

// File: tb/tb_canon_term_sweeper.sv
// Directed, table-driven bench for canon_term_sweeper at N_VARS=3 and N_VARS=4.
module tb_canon_term_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic       load3, mode3, start3, busy3, done3;
  logic [7:0] mask3;
  logic [3:0] ones3;
  canon_term_sweeper_if #(.N_VARS(3)) s3 ();

  logic        load4, mode4, start4, busy4, done4;
  logic [15:0] mask4;
  logic [4:0]  ones4;
  canon_term_sweeper_if #(.N_VARS(4)) s4 ();

`ifdef CANON_EVAL_PORT_EN
  logic [2:0] eval_in3;
  logic       eval_s3;
  logic [3:0] eval_in4;
  logic       eval_s4;
`endif

  canon_term_sweeper #(.N_VARS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load3),
    .term_mask (mask3),
    .mode      (mode3),
    .start     (start3),
    .stream    (s3),
    .busy      (busy3),
    .done      (done3),
    .ones_cnt  (ones3)
`ifdef CANON_EVAL_PORT_EN
    ,
    .eval_in   (eval_in3),
    .eval_s    (eval_s3)
`endif
  );

  canon_term_sweeper #(.N_VARS(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load4),
    .term_mask (mask4),
    .mode      (mode4),
    .start     (start4),
    .stream    (s4),
    .busy      (busy4),
    .done      (done4),
    .ones_cnt  (ones4)
`ifdef CANON_EVAL_PORT_EN
    ,
    .eval_in   (eval_in4),
    .eval_s    (eval_s4)
`endif
  );

  typedef struct {
    logic [7:0]  mask;
    logic        mode;
    logic [7:0]  exp_s;     // bit i = expected out_s at index i
    int unsigned exp_ones;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep with out_ready high; optional load at index inj_idx and load in the DONE cycle.
  task automatic run_sweep3(input logic do_load, input logic [7:0] m, input logic md,
                            input logic [7:0] exp_s, input int unsigned exp_ones,
                            input string tag, input int inj_idx, input logic done_load);
    logic [7:0] e;
    e = exp_s;
    s3.out_ready = 1'b1;
    tick();
    if (do_load) begin
      load3 = 1'b1;
      mask3 = m;
      mode3 = md;
    end
    start3 = 1'b1;
    tick();
    load3  = 1'b0;
    start3 = 1'b0;
    chk({tag, " busy_start"}, busy3, 1);
    chk({tag, " ones_start"}, ones3, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s idx%0d", tag, i), s3.out_idx, i);
      chk($sformatf("%s s%0d", tag, i), s3.out_s, e[i]);
      chk($sformatf("%s valid%0d", tag, i), s3.out_valid, 1);
      chk($sformatf("%s nodone%0d", tag, i), done3, 0);
      if (i == inj_idx) begin
        load3  = 1'b1;
        mask3  = 8'hFF;
        mode3  = 1'b1;
        start3 = 1'b1;
      end else begin
        load3  = 1'b0;
        start3 = 1'b0;
      end
      tick();
    end
    load3  = 1'b0;
    start3 = 1'b0;
    chk({tag, " done"}, done3, 1);
    chk({tag, " busy_end"}, busy3, 0);
    chk({tag, " valid_end"}, s3.out_valid, 0);
    chk({tag, " ones"}, ones3, exp_ones);
    if (done_load) begin
      load3 = 1'b1;
      mask3 = 8'hFF;
      mode3 = 1'b1;
    end
    tick();
    load3 = 1'b0;
    chk({tag, " done_pulse"}, done3, 0);
    chk({tag, " ones_hold"}, ones3, exp_ones);
    chk({tag, " valid_idle"}, s3.out_valid, 0);
  endtask

  initial begin
    int unsigned xfers;
    int unsigned n;
    logic stalled;

    tbl[0] = '{mask: 8'hCA, mode: 1'b0, exp_s: 8'h35, exp_ones: 4};
    tbl[1] = '{mask: 8'hCA, mode: 1'b1, exp_s: 8'hCA, exp_ones: 4};
    tbl[2] = '{mask: 8'h00, mode: 1'b0, exp_s: 8'hFF, exp_ones: 8};
    tbl[3] = '{mask: 8'h0F, mode: 1'b1, exp_s: 8'h0F, exp_ones: 4};
    tbl[4] = '{mask: 8'h81, mode: 1'b0, exp_s: 8'h7E, exp_ones: 6};

    rst_n = 1'b0;
    load3 = 1'b0; mode3 = 1'b0; start3 = 1'b0; mask3 = '0; s3.out_ready = 1'b0;
    load4 = 1'b0; mode4 = 1'b0; start4 = 1'b0; mask4 = '0; s4.out_ready = 1'b0;
`ifdef CANON_EVAL_PORT_EN
    eval_in3 = '0;
    eval_in4 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", s3.out_valid, 0);
    chk("rst idx", s3.out_idx, 0);
    chk("rst s", s3.out_s, 0);
    chk("rst busy", busy3, 0);
    chk("rst done", done3, 0);
    chk("rst ones", ones3, 0);
    chk("rst ones4", ones4, 0);
`ifdef CANON_EVAL_PORT_EN
    chk("rst eval_s", eval_s3, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Reset-state function is constant 1 without any load.
    run_sweep3(1'b0, 8'h00, 1'b0, 8'hFF, 8, "t0 reset_fn", -1, 1'b0);

    for (int v = 0; v < 5; v++)
      run_sweep3(1'b1, tbl[v].mask, tbl[v].mode, tbl[v].exp_s, tbl[v].exp_ones,
                 $sformatf("tbl%0d", v), -1, 1'b0);

    // Backpressure at index 2.
    tick();
    load3 = 1'b1; mask3 = 8'hCA; mode3 = 1'b0; start3 = 1'b1;
    s3.out_ready = 1'b1;
    tick();
    load3 = 1'b0; start3 = 1'b0;
    xfers = 0; n = 0; stalled = 1'b0;
    while (!done3 && n < 60) begin
      if (s3.out_valid && s3.out_idx == 3'd2 && !stalled) begin
        s3.out_ready = 1'b0;
        stalled = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk($sformatf("t3 hold_idx%0d", k), s3.out_idx, 2);
          chk($sformatf("t3 hold_s%0d", k), s3.out_s, 1);
          chk($sformatf("t3 hold_valid%0d", k), s3.out_valid, 1);
        end
        s3.out_ready = 1'b1;
      end
      if (s3.out_valid && s3.out_ready) xfers++;
      tick();
      n++;
    end
    chk("t3 done_seen", done3, 1);
    chk("t3 stalled", stalled, 1);
    chk("t3 xfers", xfers, 8);
    chk("t3 ones", ones3, 4);
    tick();

    // Load during SWEEP ignored, load during DONE accepted.
    run_sweep3(1'b1, 8'hCA, 1'b0, 8'h35, 4, "t4 midload", 3, 1'b1);
    run_sweep3(1'b0, 8'h00, 1'b0, 8'hFF, 8, "t4 after", -1, 1'b0);

    // Asynchronous reset mid-sweep.
    tick();
    load3 = 1'b1; mask3 = 8'hCA; mode3 = 1'b0; start3 = 1'b1;
    s3.out_ready = 1'b1;
    tick();
    load3 = 1'b0; start3 = 1'b0;
    n = 0;
    while (s3.out_idx != 3'd5 && n < 20) begin
      tick();
      n++;
    end
    chk("t5 reached5", s3.out_idx, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 rst valid", s3.out_valid, 0);
    chk("t5 rst idx", s3.out_idx, 0);
    chk("t5 rst s", s3.out_s, 0);
    chk("t5 rst busy", busy3, 0);
    chk("t5 rst done", done3, 0);
    chk("t5 rst ones", ones3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep3(1'b0, 8'h00, 1'b0, 8'hFF, 8, "t5 post", -1, 1'b0);

`ifdef CANON_EVAL_PORT_EN
    eval_in3 = 3'd3;
    tick();
    chk("t5 eval_const1", eval_s3, 1);
`endif

    // N_VARS=4: single maxterm at index 0.
    s4.out_ready = 1'b1;
    tick();
    load4 = 1'b1; mask4 = 16'h0001; mode4 = 1'b0; start4 = 1'b1;
    tick();
    load4 = 1'b0; start4 = 1'b0;
    chk("t6 busy", busy4, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6 idx%0d", i), s4.out_idx, i);
      chk($sformatf("t6 s%0d", i), s4.out_s, (i == 0) ? 0 : 1);
      tick();
    end
    chk("t6 done", done4, 1);
    chk("t6 ones", ones4, 15);
    tick();
    chk("t6 done_pulse", done4, 0);
    chk("t6 ones_hold", ones4, 15);
`ifdef CANON_EVAL_PORT_EN
    eval_in4 = 4'd0;
    tick();
    chk("t6 eval0", eval_s4, 0);
    eval_in4 = 4'd9;
    tick();
    chk("t6 eval9", eval_s4, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/canon_term_sweeper.md
Name: canon_term_sweeper

Overview:
- Parametrised, sequential generalisation of the fixed 3-input canonical-form (SoP/PoS) evaluators.
- Holds a loadable 2^N_VARS-bit term mask plus a mode bit selecting minterm (SoP) or maxterm (PoS) interpretation.
- On request, sweeps every input combination in ascending order, streaming (index, value) pairs over a valid/ready handshake and counting true outputs.
- Replaces per-function hand-written modules and exhaustive-stimulus testbenches with a single self-sequencing block.

Parameters:
- N_VARS, 3, number of boolean input variables; legal range 1..8.
- TERMS, 2**N_VARS, derived localparam: truth-table size; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe that captures term_mask and mode.
- term_mask  input  TERMS  bit i set means index i is a listed term.
- mode  input  1  0 = PoS: listed indices are maxterms and output 0. 1 = SoP: listed indices are minterms and output 1.
- start  input  1  one-cycle strobe that begins a sweep.
- out_valid  output  1  out_idx/out_s hold a valid pair.
- out_ready  input  1  consumer accepts the pair.
- out_idx  output  N_VARS  input combination; MSB is the first variable (x).
- out_s  output  1  function value at out_idx.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse after the last transfer.
- ones_cnt  output  N_VARS+1  count of transferred pairs with out_s=1 in the current or last sweep.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; mask=0; mode=0; out_valid, out_idx, out_s, busy, done and ones_cnt all 0. With mask=0 and mode=0 (PoS), the function is constant 1.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - load captures term_mask and mode.
  - start moves to SWEEP. On the next cycle: busy=1, out_valid=1, out_idx=0, ones_cnt=0.
  - load and start in the same cycle: the new mask/mode apply to that sweep.
- SWEEP:
  - A transfer is out_valid && out_ready.
  - On a transfer, ones_cnt increments if out_s=1. out_idx then advances by 1 on the next cycle.
  - Without a transfer, out_idx, out_s and out_valid are held stable.
  - out_s = mask[out_idx] XNOR mode. It is registered alongside out_idx, so out_s and out_idx always update together.
  - On the transfer at out_idx=TERMS-1, the next state is DONE; out_valid=0, busy=0, done=1, and ones_cnt holds its final value (TERMS max, hence N_VARS+1 bits).
  - load and start are ignored while in SWEEP.
- DONE:
  - done is high for exactly this one cycle; the block then returns to IDLE.
  - start in DONE is ignored (it must be issued in IDLE).
  - load in DONE is accepted.
- ones_cnt holds its value in IDLE until the next start.
- No index wrap: a sweep terminates at TERMS-1 and never issues index 0 a second time.
- Sweep latency: start to first valid pair is 1 cycle. With out_ready held high, a full sweep takes TERMS cycles plus 1 DONE cycle.
- rst_n low mid-sweep aborts immediately: all outputs return to their reset values and the mask is cleared.

Optional Feature:
- Macro: CANON_EVAL_PORT_EN.
- Defined: adds input eval_in[N_VARS-1:0] and output eval_s.
  - eval_s is registered: eval_s = mask[eval_in] XNOR mode, 1-cycle latency.
  - Operates in every state, independent of the sweep.
  - Reset value of eval_s is 0.
- Undefined: both ports and the register are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package canon_pkg contains:
  - state enum {IDLE, SWEEP, DONE};
  - MODE_POS=1'b0 and MODE_SOP=1'b1;
  - a width helper function for TERMS and the ones_cnt width.
- Sub-module canon_lut: combinational term-mask index plus mode XNOR. It is instantiated once for the sweep and once more for the eval port when CANON_EVAL_PORT_EN is defined.

Test Plan:
1. N_VARS=3, mode=PoS, mask=8'b1100_1010 (maxterms 1,3,6,7), start, out_ready=1 -> out_s for idx 0..7 = 1,0,1,0,1,1,0,0; done pulses 1 cycle after idx 7; ones_cnt=4.
2. Same mask with mode=SoP -> out_s = 0,1,0,1,0,0,1,1; ones_cnt=4.
3. Backpressure: out_ready=0 for 3 cycles while out_idx=2 -> out_idx=2, out_s=1, out_valid=1 all held; sweep then completes with 8 transfers and ones_cnt=4.
4. load with mask=8'hFF asserted during SWEEP -> ignored; current sweep results unchanged; a load after done takes effect on the next sweep.
5. rst_n low while out_idx=5 -> all outputs 0 asynchronously, state IDLE; a subsequent sweep without load gives constant 1 (ones_cnt=8).
6. N_VARS=4, PoS, mask=16'h0001 -> out_s=0 only at idx 0; ones_cnt=15 (5-bit). With CANON_EVAL_PORT_EN defined, eval_in=0 gives eval_s=0 one cycle later, and eval_in=9 gives eval_s=1.
